// File: rtl/lc3_ctrl_pkg.sv
// LC-3 microsequencer shared types: state numbers, opcodes, mux encodings, control word.
// LC3_CTRL_INDIRECT_EN adds the LDI/STI states and opcode routing.
package lc3_ctrl_pkg;

  localparam int ST_W = 6;

  // Values are the LC-3 state numbers so the debug port reads like the textbook diagram.
  typedef enum logic [ST_W-1:0] {
    S0     = 6'd0,
    S1     = 6'd1,
    S2     = 6'd2,
    S3     = 6'd3,
    S5     = 6'd5,
    S9     = 6'd9,
`ifdef LC3_CTRL_INDIRECT_EN
    S10    = 6'd10,
    S11    = 6'd11,
`endif
    S12    = 6'd12,
    S14    = 6'd14,
    S16    = 6'd16,
    S18    = 6'd18,
    S22    = 6'd22,
    S23    = 6'd23,
`ifdef LC3_CTRL_INDIRECT_EN
    S24    = 6'd24,
`endif
    S25    = 6'd25,
`ifdef LC3_CTRL_INDIRECT_EN
    S26    = 6'd26,
`endif
    S27    = 6'd27,
`ifdef LC3_CTRL_INDIRECT_EN
    S29    = 6'd29,
    S31    = 6'd31,
`endif
    S32    = 6'd32,
    S33    = 6'd33,
    S35    = 6'd35,
    S_HALT = 6'd63
  } state_e;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    PCMUX_INC   = 2'd0,
    PCMUX_BUS   = 2'd1,
    PCMUX_ADDER = 2'd2
  } pcmux_e;

  typedef enum logic {
    A1_PC    = 1'b0,
    A1_BASER = 1'b1
  } addr1mux_e;

  typedef enum logic [1:0] {
    A2_ZERO  = 2'd0,
    A2_OFF6  = 2'd1,
    A2_OFF9  = 2'd2,
    A2_OFF11 = 2'd3
  } addr2mux_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_AND   = 2'd1,
    ALU_NOT   = 2'd2,
    ALU_PASSA = 2'd3
  } aluk_e;

  typedef struct packed {
    logic      ldmar;
    logic      ldmdr;
    logic      ldir;
    logic      ldben;
    logic      ldreg;
    logic      ldcc;
    logic      ldpc;
    logic      gatepc;
    logic      gatemdr;
    logic      gatealu;
    logic      gatemarmux;
    pcmux_e    pcmux;
    addr1mux_e addr1mux;
    addr2mux_e addr2mux;
    aluk_e     aluk;
    logic      mio_en;
    logic      mem_en;
    logic      mem_we;
    logic      halted;
  } ctrl_t;

  // Opcode IR[15:12] to first execute state; unsupported opcodes route to HALT.
  function automatic state_e op_dispatch(input logic [3:0] op);
    state_e nxt;
    nxt = S_HALT;
    case (op)
      OP_BR:   nxt = S0;
      OP_ADD:  nxt = S1;
      OP_LD:   nxt = S2;
      OP_ST:   nxt = S3;
      OP_AND:  nxt = S5;
      OP_NOT:  nxt = S9;
      OP_JMP:  nxt = S12;
      OP_LEA:  nxt = S14;
`ifdef LC3_CTRL_INDIRECT_EN
      OP_LDI:  nxt = S10;
      OP_STI:  nxt = S11;
`endif
      default: nxt = S_HALT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/lc3_ctrl_decode.sv
// Combinational state -> control word lookup for the LC-3 microsequencer (Moore outputs).
// LC3_CTRL_INDIRECT_EN enables the extra LDI/STI state rows.
module lc3_ctrl_decode
  import lc3_ctrl_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S18: begin
        ctrl.gatepc = 1'b1;
        ctrl.ldmar  = 1'b1;
        ctrl.ldpc   = 1'b1;
        ctrl.pcmux  = PCMUX_INC;
      end
      S33, S25: begin
        ctrl.mem_en = 1'b1;
        ctrl.mio_en = 1'b1;
        ctrl.ldmdr  = 1'b1;
      end
      S35: begin
        ctrl.gatemdr = 1'b1;
        ctrl.ldir    = 1'b1;
      end
      S32: ctrl.ldben = 1'b1;
      S1, S5, S9: begin
        ctrl.gatealu = 1'b1;
        ctrl.ldreg   = 1'b1;
        ctrl.ldcc    = 1'b1;
        ctrl.aluk    = (state == S1) ? ALU_ADD : (state == S5) ? ALU_AND : ALU_NOT;
      end
      S22: begin
        ctrl.pcmux    = PCMUX_ADDER;
        ctrl.addr1mux = A1_PC;
        ctrl.addr2mux = A2_OFF9;
        ctrl.ldpc     = 1'b1;
      end
      S12: begin
        ctrl.pcmux    = PCMUX_ADDER;
        ctrl.addr1mux = A1_BASER;
        ctrl.addr2mux = A2_ZERO;
        ctrl.ldpc     = 1'b1;
      end
      S14: begin
        ctrl.gatemarmux = 1'b1;
        ctrl.addr1mux   = A1_PC;
        ctrl.addr2mux   = A2_OFF9;
        ctrl.ldreg      = 1'b1;
      end
      S2, S3: begin
        ctrl.gatemarmux = 1'b1;
        ctrl.addr2mux   = A2_OFF9;
        ctrl.ldmar      = 1'b1;
      end
      S27: begin
        ctrl.gatemdr = 1'b1;
        ctrl.ldreg   = 1'b1;
        ctrl.ldcc    = 1'b1;
      end
      // Store data goes through the ALU and into MDR from the bus, not memory.
      S23: begin
        ctrl.gatealu = 1'b1;
        ctrl.aluk    = ALU_PASSA;
        ctrl.ldmdr   = 1'b1;
        ctrl.mio_en  = 1'b0;
      end
      S16: begin
        ctrl.mem_en = 1'b1;
        ctrl.mem_we = 1'b1;
      end
`ifdef LC3_CTRL_INDIRECT_EN
      S10, S11: begin
        ctrl.gatemarmux = 1'b1;
        ctrl.addr2mux   = A2_OFF9;
        ctrl.ldmar      = 1'b1;
      end
      S24, S29: begin
        ctrl.mem_en = 1'b1;
        ctrl.mio_en = 1'b1;
        ctrl.ldmdr  = 1'b1;
      end
      S26, S31: begin
        ctrl.gatemdr = 1'b1;
        ctrl.ldmar   = 1'b1;
      end
`endif
      S_HALT:  ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 Moore microsequencer: fetch/decode/execute, holds in memory states until mem_ready.
// Outputs follow the state register one decode level later; reset zeroes them asynchronously.
// LC3_CTRL_INDIRECT_EN adds LDI/STI.
module lc3_ctrl_fsm
  import lc3_ctrl_pkg::*;
#(
  parameter int STATE_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        IR,
  input  logic               BEN,
  input  logic               mem_ready,
  output logic               LDMAR,
  output logic               LDMDR,
  output logic               LDIR,
  output logic               LDBEN,
  output logic               LDREG,
  output logic               LDCC,
  output logic               LDPC,
  output logic               GATEPC,
  output logic               GATEMDR,
  output logic               GATEALU,
  output logic               GATEMARMUX,
  output logic [1:0]         PCMUX,
  output logic               ADDR1MUX,
  output logic [1:0]         ADDR2MUX,
  output logic [1:0]         ALUK,
  output logic               MIO_EN,
  output logic               MEM_EN,
  output logic               MEM_WE,
  output logic               halted,
  output logic [STATE_W-1:0] state
);

  state_e state_q;
  ctrl_t  ctrl_dec;
  ctrl_t  ctrl;
  logic   unused_ir;

  assign unused_ir = ^IR[11:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S18;
    end else begin
      case (state_q)
        S18:    state_q <= S33;
        S33:    if (mem_ready) state_q <= S35;
        S35:    state_q <= S32;
        S32:    state_q <= op_dispatch(IR[15:12]);
        S1:     state_q <= S18;
        S5:     state_q <= S18;
        S9:     state_q <= S18;
        // BEN here is what S32's LDBEN captured on the S32->S0 edge.
        S0:     state_q <= BEN ? S22 : S18;
        S22:    state_q <= S18;
        S12:    state_q <= S18;
        S14:    state_q <= S18;
        S2:     state_q <= S25;
        S3:     state_q <= S23;
        S25:    if (mem_ready) state_q <= S27;
        S27:    state_q <= S18;
        S23:    state_q <= S16;
        S16:    if (mem_ready) state_q <= S18;
`ifdef LC3_CTRL_INDIRECT_EN
        S10:    state_q <= S24;
        S24:    if (mem_ready) state_q <= S26;
        S26:    state_q <= S25;
        S11:    state_q <= S29;
        S29:    if (mem_ready) state_q <= S31;
        S31:    state_q <= S23;
`endif
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_HALT;
      endcase
    end
  end

  lc3_ctrl_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl_dec)
  );

  // Gating with rst lets an in-flight memory request drop without waiting for a clock.
  assign ctrl = rst ? ctrl_dec : '0;

  assign LDMAR      = ctrl.ldmar;
  assign LDMDR      = ctrl.ldmdr;
  assign LDIR       = ctrl.ldir;
  assign LDBEN      = ctrl.ldben;
  assign LDREG      = ctrl.ldreg;
  assign LDCC       = ctrl.ldcc;
  assign LDPC       = ctrl.ldpc;
  assign GATEPC     = ctrl.gatepc;
  assign GATEMDR    = ctrl.gatemdr;
  assign GATEALU    = ctrl.gatealu;
  assign GATEMARMUX = ctrl.gatemarmux;
  assign PCMUX      = ctrl.pcmux;
  assign ADDR1MUX   = ctrl.addr1mux;
  assign ADDR2MUX   = ctrl.addr2mux;
  assign ALUK       = ctrl.aluk;
  assign MIO_EN     = ctrl.mio_en;
  assign MEM_EN     = ctrl.mem_en;
  assign MEM_WE     = ctrl.mem_we;
  assign halted     = ctrl.halted;
  assign state      = STATE_W'(state_q);

endmodule
